// File: rtl/pixel_pkg.sv
// Shared constants for the pixel readout sequencer: FSM state codes and default geometry.
package pixel_pkg;

    localparam int DEF_N_ROWS       = 2;
    localparam int DEF_N_COLS       = 2;
    localparam int DEF_ADC_W        = 8;
    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_EXP_W        = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ERASE   = 3'd1;
    localparam state_t ST_EXPOSE  = 3'd2;
    localparam state_t ST_CONVERT = 3'd3;
    localparam state_t ST_READ    = 3'd4;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_readout_seq_out_reg.sv
// Single-entry valid/ready holding register for captured pixel rows.
module pixel_out_reg #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [ROW_W-1:0]  cap_row,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_valid,
    output logic              can_capture
);

    logic [DATA_W-1:0] data_reg;
    logic [ROW_W-1:0]  row_reg;
    logic              valid_reg;

    // A new row may enter when the slot is empty or is being drained this cycle.
    assign can_capture = !valid_reg || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg  <= '0;
            row_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (capture) begin
            data_reg  <= cap_data;
            row_reg   <= cap_row;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_data  = data_reg;
    assign out_row   = row_reg;
    assign out_valid = valid_reg;

endmodule

// File: rtl/pixel_readout_seq.sv
// Pixel array sequencer: erase, expose, ramp convert and row-by-row readout
// onto a valid/ready stream, with single-shot or continuous framing.
module pixel_readout_seq
    import pixel_pkg::*;
#(
    parameter int N_ROWS       = DEF_N_ROWS,
    parameter int N_COLS       = DEF_N_COLS,
    parameter int ADC_W        = DEF_ADC_W,
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int EXP_W        = DEF_EXP_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             continuous,
    input  logic [EXP_W-1:0]                 exp_cycles,
    output logic                             erase,
    output logic                             expose,
    output logic                             convert,
    output logic [N_ROWS-1:0]                read,
    output logic                             anaBias1,
    output logic                             anaRamp,
    output logic                             anaReset,
    inout  wire  [N_ROWS*N_COLS*ADC_W-1:0]   pixData,
    output logic [N_COLS*ADC_W-1:0]          out_data,
    output logic [idx_w(N_ROWS)-1:0]         out_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int ROW_BITS = N_COLS * ADC_W;
    localparam int RW       = idx_w(N_ROWS);
    localparam int ERASE_W  = idx_w(ERASE_CYCLES);
    localparam int CNT_W    = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;
    localparam logic [ADC_W-1:0] RAMP_MAX = '1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ADC_W-1:0]   ramp_reg, ramp_next;
    logic [RW-1:0]      row_reg, row_next;
    logic [EXP_W-1:0]   exp_reg, exp_next;
    logic               frame_done_reg, frame_done_next;

    logic               capture;
    logic               can_capture;
    logic               last_row;
    logic [EXP_W-1:0]   exp_last;
    logic [ADC_W-1:0]   lane_val;
    logic [ROW_BITS-1:0] row_data;

    // Exposure of zero behaves as one cycle, so the last count index saturates at 0.
    assign exp_last = (exp_reg == '0) ? '0 : exp_reg - EXP_W'(1);
    assign last_row = (row_reg == RW'(N_ROWS - 1));
    assign capture  = (state_reg == ST_READ) && can_capture;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        ramp_next       = ramp_reg;
        row_next        = row_reg;
        exp_next        = exp_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ERASE;
                    cnt_next   = '0;
                    exp_next   = exp_cycles;
                end
            end
            ST_ERASE: begin
                if (cnt_reg == CNT_W'(ERASE_CYCLES - 1)) begin
                    state_next = ST_EXPOSE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (cnt_reg == CNT_W'(exp_last)) begin
                    state_next = ST_CONVERT;
                    cnt_next   = '0;
                    ramp_next  = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                // Ramp sweeps every code exactly once and never wraps.
                if (ramp_reg == RAMP_MAX) begin
                    state_next = ST_READ;
                    ramp_next  = '0;
                    row_next   = '0;
                end else begin
                    ramp_next = ramp_reg + ADC_W'(1);
                end
            end
            ST_READ: begin
                if (capture) begin
                    if (last_row) begin
                        frame_done_next = 1'b1;
                        row_next        = '0;
                        if (continuous) begin
                            state_next = ST_ERASE;
                            cnt_next   = '0;
                            exp_next   = exp_cycles;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        row_next = row_reg + RW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            ramp_reg       <= '0;
            row_reg        <= '0;
            exp_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ramp_reg       <= ramp_next;
            row_reg        <= row_next;
            exp_reg        <= exp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign erase      = (state_reg == ST_ERASE);
    assign expose     = (state_reg == ST_EXPOSE);
    assign convert    = (state_reg == ST_CONVERT);
    assign anaReset   = erase;
    assign anaBias1   = expose & clk;
    assign anaRamp    = convert & clk;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;

    assign lane_val = convert ? ramp_reg : '0;

    // A row's lanes are released to the pixels only while that row is selected.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N_ROWS; gi++) begin : g_row
            assign read[gi] = (state_reg == ST_READ) && (row_reg == RW'(gi));
            for (gj = 0; gj < N_COLS; gj++) begin : g_col
                assign pixData[(gi*N_COLS + gj)*ADC_W +: ADC_W] =
                    read[gi] ? {ADC_W{1'bz}} : lane_val;
            end
        end
    endgenerate

    assign row_data = pixData[row_reg*ROW_BITS +: ROW_BITS];

    pixel_out_reg #(
        .DATA_W (ROW_BITS),
        .ROW_W  (RW)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .cap_data    (row_data),
        .cap_row     (row_reg),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .can_capture (can_capture)
    );

endmodule
